// File: rtl/avalon_s_burst_mem.sv
// Avalon-MM burst responder over a word-addressed on-chip memory; single/burst writes with byte enables.
// Read beats start RD_LAT cycles after acceptance, back to back; waitrequest holds off commands during read return.
module avalon_s_burst_mem #(
  parameter int DATA_W = 1024,
  parameter int BE_W   = DATA_W / 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       address,
  input  logic [BE_W-1:0]   byteenable,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [10:0]       burstcount,
  input  logic              beginbursttransfer,
  output logic [DATA_W-1:0] readdata,
  output logic              waitrequest,
  output logic              readdatavalid
);

  localparam int ADDR_LSB = $clog2(BE_W);
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((RD_LAT >= 2) ? RD_LAT - 2 : 0);
  localparam bit FIRE_ON_ACCEPT = (RD_LAT == 1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] addr_q, addr_nxt;
  logic [10:0]      rem_q, rem_nxt;
  logic [LAT_W-1:0] lat_q, lat_nxt;
  logic             init_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] base_idx;
  logic [10:0]      beats;
  logic             cmd_ok, wr_acc, rd_acc;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic             fire;
  logic [IDX_W-1:0] fire_idx;

  logic unused_bits;
  assign unused_bits = &{1'b0, beginbursttransfer, address};

  assign base_idx    = address[ADDR_LSB +: IDX_W];
  assign beats       = (burstcount == 11'd0) ? 11'd1 : burstcount;
  // init_q keeps the slave stalled until the first edge after reset release
  assign waitrequest = init_q | (state == RD_BURST);
  assign cmd_ok      = chipselect & ~waitrequest;
  assign wr_acc      = cmd_ok & write;
  assign rd_acc      = cmd_ok & read & ~write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    rem_nxt   = rem_q;
    lat_nxt   = lat_q;
    mem_we    = 1'b0;
    mem_widx  = addr_q;
    fire      = 1'b0;
    fire_idx  = addr_q;
    case (state)
      IDLE: begin
        if (wr_acc) begin
          mem_we   = 1'b1;
          mem_widx = base_idx;
          addr_nxt = base_idx + IDX_W'(1);
          rem_nxt  = beats - 11'd1;
          if (beats != 11'd1) state_nxt = WR_BURST;
        end else if (rd_acc) begin
          // with RD_LAT==1 beat 0 is fetched on the acceptance edge itself
          state_nxt = RD_BURST;
          lat_nxt   = LAT_LOAD;
          fire      = FIRE_ON_ACCEPT;
          fire_idx  = base_idx;
          addr_nxt  = base_idx + IDX_W'(FIRE_ON_ACCEPT);
          rem_nxt   = beats - 11'(FIRE_ON_ACCEPT);
        end
      end
      WR_BURST: begin
        if (wr_acc) begin
          mem_we   = 1'b1;
          addr_nxt = addr_q + IDX_W'(1);
          rem_nxt  = rem_q - 11'd1;
          if (rem_q == 11'd1) state_nxt = IDLE;
        end
      end
      RD_BURST: begin
        if (lat_q != '0) begin
          lat_nxt = lat_q - LAT_W'(1);
        end else if (rem_q != 11'd0) begin
          fire     = 1'b1;
          addr_nxt = addr_q + IDX_W'(1);
          rem_nxt  = rem_q - 11'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q        <= '0;
      rem_q         <= '0;
      lat_q         <= '0;
      init_q        <= 1'b1;
      readdatavalid <= 1'b0;
      readdata      <= '0;
    end else begin
      addr_q        <= addr_nxt;
      rem_q         <= rem_nxt;
      lat_q         <= lat_nxt;
      init_q        <= 1'b0;
      readdatavalid <= fire;
      if (fire) readdata <= mem[fire_idx];
    end
  end

  // storage is deliberately not reset; contents survive reset_n
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) mem[mem_widx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avalon_s_burst_mem.sv
// Directed bench for avalon_s_burst_mem: reset, single/burst writes, byte merge, wrap, conflicts, mid-burst reset.
module tb_avalon_s_burst_mem;
  localparam int DATA_W = 1024;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [10:0]       burstcount;
  logic              beginbursttransfer;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;
  logic              readdatavalid;

  int checks = 0;
  int failures = 0;

  logic              cap_vld  [16];
  logic              cap_wait [16];
  logic [DATA_W-1:0] cap_dat  [16];

  localparam logic [BE_W-1:0] BE_ALL = {BE_W{1'b1}};

  avalon_s_burst_mem #(.DATA_W(DATA_W), .BE_W(BE_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
    .readdata(readdata), .waitrequest(waitrequest), .readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pat(input int s);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++)
      r[i*32 +: 32] = (32'(s) * 32'h0101_0101) ^ (32'(i) * 32'h1357_9BDF) ^ 32'hC0DE_0000;
    r[7:0] = 8'h80 | 8'(s);
    return r;
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_beat(input logic [31:0] a, input logic [10:0] bc,
                         input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; burstcount = bc; writedata = d; byteenable = be;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  // Issues a read, then samples outputs after the acceptance edge (j=0) and ncyc-1 further edges.
  task automatic run_read(input logic [31:0] a, input logic [10:0] bc, input int ncyc);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a; burstcount = bc;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      cap_vld[j] = readdatavalid; cap_wait[j] = waitrequest; cap_dat[j] = readdata;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL reset_wait: got %b expected 1", waitrequest); end
    checks++; if (readdatavalid !== 1'b0) begin failures++; $display("FAIL reset_rdv: got %b expected 0", readdatavalid); end
    checks++; if (readdata !== '0) begin failures++; $display("FAIL reset_readdata: got %h expected 0", readdata[127:0]); end
    @(negedge clk); reset_n = 1'b1; #1;
    checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL release_wait_before_edge: got %b expected 1", waitrequest); end
    @(posedge clk); #1;
    checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL release_wait_after_edge: got %b expected 0", waitrequest); end
  endtask

  task automatic test_single;
    logic [DATA_W-1:0] a;
    a = pat(1);
    wr_beat(32'h180, 11'd1, a, BE_ALL);
    run_read(32'h180, 11'd1, 4);
    for (int j = 0; j < 4; j++) begin
      checks++; if (cap_vld[j] !== (j == 1)) begin failures++; $display("FAIL single_vld[%0d]: got %b expected %b", j, cap_vld[j], (j == 1)); end
      checks++; if (cap_wait[j] !== (j <= 1)) begin failures++; $display("FAIL single_wait[%0d]: got %b expected %b", j, cap_wait[j], (j <= 1)); end
    end
    checks++; if (cap_dat[1] !== a) begin failures++; $display("FAIL single_data: got %h expected %h", cap_dat[1][127:0], a[127:0]); end
    checks++; if (cap_dat[3] !== a) begin failures++; $display("FAIL single_hold: got %h expected %h", cap_dat[3][127:0], a[127:0]); end
  endtask

  task automatic test_be_merge;
    logic [DATA_W-1:0] a, exp;
    logic [BE_W-1:0] be0;
    a = pat(2);
    be0 = '0; be0[0] = 1'b1;
    exp = {a[DATA_W-1:8], 8'h00};
    wr_beat(32'h280, 11'd1, a, BE_ALL);
    wr_beat(32'h280, 11'd1, '0, be0);
    run_read(32'h280, 11'd1, 3);
    checks++; if (cap_vld[1] !== 1'b1) begin failures++; $display("FAIL merge_vld: got %b expected 1", cap_vld[1]); end
    checks++; if (cap_dat[1] !== exp) begin failures++; $display("FAIL merge_data: got %h expected %h", cap_dat[1][127:0], exp[127:0]); end
  endtask

  task automatic test_burst_wrap;
    logic [DATA_W-1:0] bp [4];
    logic [31:0] base;
    base = 32'((DEPTH - 2) * BE_W);
    for (int k = 0; k < 4; k++) bp[k] = pat(10 + k);
    wr_beat(base, 11'd4, bp[0], BE_ALL);
    wr_beat(32'h0, 11'd4, bp[1], BE_ALL);
    idle_cycles(2);
    wr_beat(32'h0, 11'd4, bp[2], BE_ALL);
    wr_beat(32'h0, 11'd4, bp[3], BE_ALL);
    run_read(base, 11'd4, 7);
    for (int j = 0; j < 7; j++) begin
      checks++; if (cap_vld[j] !== (j >= 1 && j <= 4)) begin failures++; $display("FAIL burst_vld[%0d]: got %b expected %b", j, cap_vld[j], (j >= 1 && j <= 4)); end
      checks++; if (cap_wait[j] !== (j <= 4)) begin failures++; $display("FAIL burst_wait[%0d]: got %b expected %b", j, cap_wait[j], (j <= 4)); end
      if (j >= 1 && j <= 4) begin
        checks++; if (cap_dat[j] !== bp[j-1]) begin failures++; $display("FAIL burst_data[%0d]: got %h expected %h", j - 1, cap_dat[j][127:0], bp[j-1][127:0]); end
      end
    end
    run_read(32'h0, 11'd1, 3);
    checks++; if (cap_dat[1] !== bp[2]) begin failures++; $display("FAIL wrap_word0: got %h expected %h", cap_dat[1][127:0], bp[2][127:0]); end
  endtask

  task automatic test_conflict;
    logic [DATA_W-1:0] p4, p5, p6, p7, p8;
    p4 = pat(20); p5 = pat(21); p6 = pat(22); p7 = pat(23); p8 = pat(24);
    wr_beat(32'h400, 11'd1, p5, BE_ALL);
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 32'h380; burstcount = 11'd0; writedata = p4; byteenable = BE_ALL;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++; if (readdatavalid !== 1'b0) begin failures++; $display("FAIL conflict_rdv[%0d]: got %b expected 0", j, readdatavalid); end
      checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL conflict_wait[%0d]: got %b expected 0", j, waitrequest); end
      idle_cycles(1);
    end
    wr_beat(32'ha00, 11'd1, p6, BE_ALL);
    run_read(32'h380, 11'd1, 3);
    checks++; if (cap_dat[1] !== p4) begin failures++; $display("FAIL conflict_word7: got %h expected %h", cap_dat[1][127:0], p4[127:0]); end
    run_read(32'h400, 11'd1, 3);
    checks++; if (cap_dat[1] !== p5) begin failures++; $display("FAIL conflict_word8: got %h expected %h", cap_dat[1][127:0], p5[127:0]); end
    run_read(32'ha00, 11'd1, 3);
    checks++; if (cap_dat[1] !== p6) begin failures++; $display("FAIL conflict_word20: got %h expected %h", cap_dat[1][127:0], p6[127:0]); end

    wr_beat(32'h500, 11'd2, p7, BE_ALL);
    chipselect = 1'b1; read = 1'b1; address = 32'h500; burstcount = 11'd1;
    for (int j = 0; j < 3; j++) begin
      idle_cycles(1);
      checks++; if (readdatavalid !== 1'b0) begin failures++; $display("FAIL wrburst_read_rdv[%0d]: got %b expected 0", j, readdatavalid); end
      checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL wrburst_read_wait[%0d]: got %b expected 0", j, waitrequest); end
    end
    chipselect = 1'b0; read = 1'b0;
    wr_beat(32'h0, 11'd2, p8, BE_ALL);
    run_read(32'h500, 11'd2, 4);
    checks++; if (cap_dat[1] !== p7) begin failures++; $display("FAIL wrburst_beat0: got %h expected %h", cap_dat[1][127:0], p7[127:0]); end
    checks++; if (cap_dat[2] !== p8 || cap_vld[2] !== 1'b1) begin failures++; $display("FAIL wrburst_beat1: got %h vld %b expected %h vld 1", cap_dat[2][127:0], cap_vld[2], p8[127:0]); end
  endtask

  task automatic test_reset_mid_burst;
    for (int k = 0; k < 8; k++) wr_beat(32'h1000, 11'd8, pat(40 + k), BE_ALL);
    run_read(32'h1000, 11'd8, 4);
    for (int j = 1; j < 4; j++) begin
      checks++; if (cap_vld[j] !== 1'b1 || cap_dat[j] !== pat(40 + j - 1)) begin failures++; $display("FAIL midrst_beat[%0d]: got %h vld %b expected %h vld 1", j - 1, cap_dat[j][127:0], cap_vld[j], pat(40 + j - 1)); end
    end
    #1; reset_n = 1'b0; #1;
    checks++; if (readdatavalid !== 1'b0) begin failures++; $display("FAIL midrst_rdv_drop: got %b expected 0", readdatavalid); end
    checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL midrst_wait: got %b expected 1", waitrequest); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      checks++; if (readdatavalid !== 1'b0) begin failures++; $display("FAIL midrst_stray[%0d]: got %b expected 0", j, readdatavalid); end
      if (j == 0) begin
        checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL midrst_idle_wait: got %b expected 0", waitrequest); end
      end
    end
    run_read(32'h1080, 11'd1, 3);
    checks++; if (cap_vld[1] !== 1'b1 || cap_dat[1] !== pat(41)) begin failures++; $display("FAIL midrst_after: got %h vld %b expected %h vld 1", cap_dat[1][127:0], cap_vld[1], pat(41)); end
  endtask

  initial begin
    reset_n = 1'b0; address = '0; byteenable = BE_ALL; chipselect = 1'b0;
    read = 1'b0; write = 1'b0; writedata = '0; burstcount = 11'd1; beginbursttransfer = 1'b0;
    test_reset();
    test_single();
    test_be_merge();
    test_burst_wrap();
    test_conflict();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_s_burst_mem.md
# avalon_s_burst_mem

Avalon-MM burst slave (responder) backed by an on-chip word-addressed memory. It is the responding end of the wide (1024-bit data, 11-bit burstcount) Avalon master interface used by the curl unit benches and datapath. It accepts single and burst writes with per-byte enables, and returns read bursts with a fixed latency. It provides a synthesizable memory target for the curl_avalon block and its testbenches.

## Interface
- DATA_W, 1024, data bus width in bits (multiple of 8)
- BE_W, DATA_W/8, byteenable width; byte address LSBs dropped = log2(BE_W)
- DEPTH, 256, memory depth in DATA_W words (power of 2)
- RD_LAT, 2, cycles from read-command acceptance to first readdatavalid (>=1)

- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  32  byte address of first beat
- byteenable  in  BE_W  per-byte write enable
- chipselect  in  1  slave select; read/write ignored when low
- read  in  1  read command
- write  in  1  write command / write beat
- writedata  in  DATA_W  write data
- burstcount  in  11  beats in burst; 0 treated as 1
- beginbursttransfer  in  1  informational only; ignored
- readdata  out  DATA_W  read data beat
- waitrequest  out  1  stall; command/beat not accepted while high
- readdatavalid  out  1  readdata valid this cycle

## Operation
- Word index = (address >> log2(BE_W)) mod DEPTH. Beat addresses increment by 1 word and wrap from DEPTH-1 to 0.
- Accept: a command or beat is accepted on an edge where chipselect & (read|write) & !waitrequest.
- States: IDLE, WR_BURST, RD_BURST.
- IDLE: waitrequest=0.
  - write accepted: beat 0 is written to the base word; the base word and remaining count (burstcount-1) are latched. Go to WR_BURST if remaining>0, else stay in IDLE.
  - read accepted: the base word and count are latched. Go to RD_BURST.
  - read and write both high: write is taken and read is ignored.
- WR_BURST: waitrequest=0.
  - Each accepted write beat writes the next word, with bytes gated by byteenable, and decrements the remaining count. Return to IDLE after the last beat.
  - A read asserted in WR_BURST is ignored; no data is returned.
  - Cycles with write low are idle gaps and do not count.
- RD_BURST: waitrequest=1.
  - Beats are issued on consecutive cycles, with no gaps, in address order.
  - The state returns to IDLE in the cycle after the last readdatavalid.
- Byteenable applies to writes only; reads always return the full word.
- Reads return the memory contents as of the acceptance edge onward; there is no write hazard, because writes cannot be accepted during RD_BURST.

## Timing
- Reset (asynchronous assert):
  - waitrequest=1, readdatavalid=0, readdata=0, state=IDLE, counters cleared.
  - Memory contents are undefined and are not cleared.
  - waitrequest drops to 0 on the first rising edge after reset_n deasserts.
- Reset mid-burst: the burst is abandoned immediately. No further readdatavalid is raised, and a partial write burst keeps the beats already written.
- Write: each beat is written on its acceptance edge. A read issued on the next cycle sees the data.
- Read: if accepted at edge N, beat k (k=0..B-1) is presented with readdatavalid=1 in the cycle after edge N+RD_LAT-1+k.
  - readdatavalid=0 at all other times.
  - readdata holds its last value when not valid.
- waitrequest=1 from the cycle after read acceptance through the cycle of the last beat. The next command can be accepted at the edge ending the cycle that follows the last beat.
- Minimum read turnaround for a single beat is RD_LAT+1 cycles between command acceptances.

## Test plan
- Reset: hold reset_n=0 for 5 cycles -> waitrequest=1, readdatavalid=0, readdata=0; waitrequest=0 on the first edge after release.
- Single write then read: write word 3 (address 0x180), data pattern A, byteenable all ones; read burstcount=1 -> one readdatavalid RD_LAT cycles after acceptance, readdata=A.
- Byte-enable merge: write pattern A to word 5, then write 0 with only byteenable[0] set; read word 5 -> byte 0 = 0x00, other bytes from A.
- Write burst with gaps and wrap: burstcount=4 at word DEPTH-2, with write deasserted for 2 cycles between beats 1 and 2; read burstcount=4 from the same address -> 4 consecutive valid beats from words DEPTH-2, DEPTH-1, 0, 1 in order. waitrequest=1 during the read return.
- Read/write conflict and burstcount=0: read and write asserted together with burstcount=0 -> only the single-beat write occurs and no readdatavalid follows. A read asserted during WR_BURST is ignored.
- Reset during a read burst of 8: assert reset_n=0 after beat 2 -> readdatavalid drops immediately; after release the slave is IDLE with waitrequest=0 and no stray beats.
